// File: rtl/multicycle_controller.sv
`default_nettype none
// multicycle_controller: Moore control unit for a multicycle MIPS datapath.
// FETCH/MEMRD/MEMWR stretch by MEMWAIT cycles; their strobes fire only in the final cycle.
module multicycle_controller #(
  parameter int unsigned MEMWAIT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic       pcen,
  output logic       illegal,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [3:0] WAIT_LAST = 4'(MEMWAIT);

  state_t     state_q, state_d;
  logic [3:0] wcnt_q, wcnt_d;
  logic       run_q;
  logic       op_known;
  logic       final_d;

  logic       iord_q, memwrite_q, irwrite_q, pcwrite_q, regdst_q, memtoreg_q;
  logic       regwrite_q, alusrca_q, branch_q;
  logic [1:0] alusrcb_q, pcsrc_q, aluop_q;
  logic       iord_d, memwrite_d, irwrite_d, pcwrite_d, regdst_d, memtoreg_d;
  logic       regwrite_d, alusrca_d, branch_d;
  logic [1:0] alusrcb_d, pcsrc_d, aluop_d;

  always_comb begin
    op_known = 1'b0;
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: op_known = 1'b1;
      default:                                        op_known = 1'b0;
    endcase
  end

  // run_q low means the FETCH held during reset is only a hold value; the first edge after release enters FETCH fresh.
  always_comb begin
    state_d = state_q;
    wcnt_d  = 4'd0;
    if (!run_q) begin
      state_d = S_FETCH;
    end else if ((state_q == S_FETCH || state_q == S_MEMRD || state_q == S_MEMWR) &&
                 (wcnt_q != WAIT_LAST)) begin
      state_d = state_q;
      wcnt_d  = wcnt_q + 4'd1;
    end else begin
      case (state_q)
        S_FETCH: state_d = S_DECODE;
        S_DECODE: begin
          case (op)
            OP_LW, OP_SW: state_d = S_MEMADR;
            OP_RTYPE:     state_d = S_EXECUTE;
            OP_BEQ:       state_d = S_BRANCH;
            OP_ADDI:      state_d = S_ADDIEXEC;
            OP_J:         state_d = S_JUMP;
            default:      state_d = S_FETCH;
          endcase
        end
        S_MEMADR:   state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD:    state_d = S_MEMWB;
        S_EXECUTE:  state_d = S_ALUWB;
        S_ADDIEXEC: state_d = S_ADDIWB;
        default:    state_d = S_FETCH;
      endcase
    end
  end

  assign final_d = (wcnt_d == WAIT_LAST);

  always_comb begin
    iord_d     = 1'b0;
    memwrite_d = 1'b0;
    irwrite_d  = 1'b0;
    pcwrite_d  = 1'b0;
    regdst_d   = 1'b0;
    memtoreg_d = 1'b0;
    regwrite_d = 1'b0;
    alusrca_d  = 1'b0;
    branch_d   = 1'b0;
    alusrcb_d  = 2'b00;
    pcsrc_d    = 2'b00;
    aluop_d    = 2'b00;
    case (state_d)
      S_FETCH: begin
        alusrcb_d = 2'b01;
        irwrite_d = final_d;
        pcwrite_d = final_d;
      end
      S_DECODE:  alusrcb_d = 2'b11;
      S_MEMADR: begin
        alusrca_d = 1'b1;
        alusrcb_d = 2'b10;
      end
      S_MEMRD:   iord_d = 1'b1;
      S_MEMWB: begin
        memtoreg_d = 1'b1;
        regwrite_d = 1'b1;
      end
      S_MEMWR: begin
        iord_d     = 1'b1;
        memwrite_d = final_d;
      end
      S_EXECUTE: begin
        alusrca_d = 1'b1;
        aluop_d   = 2'b10;
      end
      S_ALUWB: begin
        regdst_d   = 1'b1;
        regwrite_d = 1'b1;
      end
      S_BRANCH: begin
        alusrca_d = 1'b1;
        aluop_d   = 2'b01;
        pcsrc_d   = 2'b01;
        branch_d  = 1'b1;
      end
      S_ADDIEXEC: begin
        alusrca_d = 1'b1;
        alusrcb_d = 2'b10;
      end
      S_ADDIWB:  regwrite_d = 1'b1;
      S_JUMP: begin
        pcsrc_d   = 2'b10;
        pcwrite_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_FETCH;
      wcnt_q     <= 4'd0;
      run_q      <= 1'b0;
      iord_q     <= 1'b0;
      memwrite_q <= 1'b0;
      irwrite_q  <= 1'b0;
      pcwrite_q  <= 1'b0;
      regdst_q   <= 1'b0;
      memtoreg_q <= 1'b0;
      regwrite_q <= 1'b0;
      alusrca_q  <= 1'b0;
      branch_q   <= 1'b0;
      alusrcb_q  <= 2'b01;
      pcsrc_q    <= 2'b00;
      aluop_q    <= 2'b00;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      run_q      <= 1'b1;
      iord_q     <= iord_d;
      memwrite_q <= memwrite_d;
      irwrite_q  <= irwrite_d;
      pcwrite_q  <= pcwrite_d;
      regdst_q   <= regdst_d;
      memtoreg_q <= memtoreg_d;
      regwrite_q <= regwrite_d;
      alusrca_q  <= alusrca_d;
      branch_q   <= branch_d;
      alusrcb_q  <= alusrcb_d;
      pcsrc_q    <= pcsrc_d;
      aluop_q    <= aluop_d;
    end
  end

  always_comb begin
    alucontrol = 3'b010;
    case (aluop_q)
      2'b00: alucontrol = 3'b010;
      2'b01: alucontrol = 3'b110;
      2'b10: begin
        case (funct)
          6'b100000: alucontrol = 3'b010;
          6'b100010: alucontrol = 3'b110;
          6'b100100: alucontrol = 3'b000;
          6'b100101: alucontrol = 3'b001;
          6'b101010: alucontrol = 3'b111;
          default:   alucontrol = 3'b010;
        endcase
      end
      default: alucontrol = 3'b010;
    endcase
  end

  // Branch resolution uses the live zero flag so the PC updates within the BRANCH cycle.
  assign pcen     = reset & (pcwrite_q | (branch_q & zero));
  assign illegal  = reset & run_q & (state_q == S_DECODE) & ~op_known;
  assign iord     = iord_q;
  assign memwrite = reset & memwrite_q;
  assign irwrite  = reset & irwrite_q;
  assign regdst   = regdst_q;
  assign memtoreg = memtoreg_q;
  assign regwrite = reset & regwrite_q;
  assign alusrca  = alusrca_q;
  assign alusrcb  = alusrcb_q;
  assign pcsrc    = pcsrc_q;
  assign state    = state_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// tb_multicycle_controller: randomized instruction streams on three wait-state variants,
// compared cycle by cycle against a path-table reference model.
module tb_multicycle_controller;

  localparam logic [5:0] RT   = 6'b000000;
  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] J    = 6'b000010;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_v   [3];
  logic [5:0]  op_v    [3];
  logic [5:0]  funct_v [3];
  logic        zero_v  [3];
  logic [19:0] obs_v   [3];

  int n_tests = 0;
  int n_fail  = 0;
  logic [5:0] ro, rf;
  logic       rz;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, pcen, illegal;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state;
    multicycle_controller #(.MEMWAIT((g == 0) ? 0 : g + 1)) u_dut (
      .clk(clk), .reset(rst_v[g]), .op(op_v[g]), .funct(funct_v[g]), .zero(zero_v[g]),
      .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst),
      .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca), .pcen(pcen),
      .illegal(illegal), .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol),
      .state(state)
    );
    assign obs_v[g] = {state, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
                       alusrca, pcen, illegal, alusrcb, pcsrc, alucontrol};
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic int wait_of(input int d);
    return (d == 0) ? 0 : d + 1;
  endfunction

  function automatic logic [2:0] alu_ref(input logic [1:0] aluop, input logic [5:0] f);
    if (aluop == 2'b00) return 3'b010;
    if (aluop == 2'b01) return 3'b110;
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Expected output vector for one cycle in state s; fin marks the last cycle of a stretched state.
  function automatic logic [19:0] exp_vec(input logic [3:0] s, input bit fin,
                                          input logic [5:0] o, input logic [5:0] f, input logic z);
    logic iord, mw, irw, rd, m2r, rw, asa, pcw, br, ill;
    logic [1:0] asb, pcs, aluop;
    {iord, mw, irw, rd, m2r, rw, asa, pcw, br, ill} = '0;
    asb = 2'b00; pcs = 2'b00; aluop = 2'b00;
    case (s)
      4'd0:  begin asb = 2'b01; irw = fin; pcw = fin; end
      4'd1:  begin asb = 2'b11; ill = !(o inside {RT, LW, SW, BEQ, ADDI, J}); end
      4'd2:  begin asa = 1'b1; asb = 2'b10; end
      4'd3:  iord = 1'b1;
      4'd4:  begin m2r = 1'b1; rw = 1'b1; end
      4'd5:  begin iord = 1'b1; mw = fin; end
      4'd6:  begin asa = 1'b1; aluop = 2'b10; end
      4'd7:  begin rd = 1'b1; rw = 1'b1; end
      4'd8:  begin asa = 1'b1; aluop = 2'b01; pcs = 2'b01; br = 1'b1; end
      4'd9:  begin asa = 1'b1; asb = 2'b10; end
      4'd10: rw = 1'b1;
      4'd11: begin pcs = 2'b10; pcw = 1'b1; end
      default: ;
    endcase
    return {s, iord, mw, irw, rd, m2r, rw, asa, pcw | (br & z), ill, asb, pcs, alu_ref(aluop, f)};
  endfunction

  // Runs one instruction on DUT d; ncyc>0 stops after that many cycles.
  task automatic run_instr(input int d, input logic [5:0] o, input logic [5:0] f,
                           input logic z, input int ncyc);
    logic [4:0]  q[$];
    logic [3:0]  path[$];
    logic [19:0] e;
    int w, lim;
    w = wait_of(d);
    for (int k = 0; k <= w; k++) q.push_back({(k == w), 4'd0});
    q.push_back({1'b1, 4'd1});
    case (o)
      LW:      path = '{4'd2, 4'd3, 4'd4};
      SW:      path = '{4'd2, 4'd5};
      RT:      path = '{4'd6, 4'd7};
      BEQ:     path = '{4'd8};
      ADDI:    path = '{4'd9, 4'd10};
      J:       path = '{4'd11};
      default: path = {};
    endcase
    foreach (path[p]) begin
      if (path[p] == 4'd3 || path[p] == 4'd5)
        for (int k = 0; k <= w; k++) q.push_back({(k == w), path[p]});
      else
        q.push_back({1'b1, path[p]});
    end
    lim = (ncyc > 0 && ncyc < q.size()) ? ncyc : q.size();
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      e = exp_vec(q[i][3:0], q[i][4], o, f, z);
      check($sformatf("d%0d op%02h f%02h z%0d cyc%0d", d, o, f, z, i), {12'd0, obs_v[d]}, {12'd0, e});
      // Instruction register loads at the end of the final FETCH cycle.
      if (q[i][3:0] == 4'd0 && q[i][4]) begin
        op_v[d] = o; funct_v[d] = f; zero_v[d] = z;
      end
    end
  endtask

  task automatic check_quiet(input int d, input string tag);
    check($sformatf("d%0d %s state", d, tag), {28'd0, obs_v[d][19:16]}, 32'd0);
    check($sformatf("d%0d %s strobes", d, tag),
          {28'd0, obs_v[d][14], obs_v[d][13], obs_v[d][10], obs_v[d][8]}, 32'd0);
  endtask

  task automatic do_release(input int d);
    @(negedge clk);
    check_quiet(d, "in_reset");
    rst_v[d] = 1'b1;
    #1;
    check_quiet(d, "post_release");
  endtask

  task automatic random_instrs(input int d, input int n);
    for (int k = 0; k < n; k++) begin
      case ($urandom_range(0, 6))
        0: ro = LW;
        1: ro = SW;
        2: ro = RT;
        3: ro = BEQ;
        4: ro = ADDI;
        5: ro = J;
        default: ro = 6'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0: rf = 6'b100000;
        1: rf = 6'b100010;
        2: rf = 6'b100100;
        3: rf = 6'b100101;
        4: rf = 6'b101010;
        default: rf = 6'($urandom);
      endcase
      rz = 1'($urandom);
      run_instr(d, ro, rf, rz, 0);
    end
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst_v[d] = 1'b0; op_v[d] = RT; funct_v[d] = 6'd0; zero_v[d] = 1'b0;
    end
    repeat (3) @(negedge clk);

    do_release(0);
    run_instr(0, LW,        6'd0,      1'b0, 0);
    run_instr(0, BEQ,       6'd0,      1'b1, 0);
    run_instr(0, BEQ,       6'd0,      1'b0, 0);
    run_instr(0, RT,        6'b101010, 1'b0, 0);
    run_instr(0, RT,        6'b111111, 1'b0, 0);
    run_instr(0, 6'b111111, 6'd0,      1'b0, 0);
    run_instr(0, SW,        6'd0,      1'b0, 0);
    run_instr(0, ADDI,      6'd0,      1'b0, 0);
    run_instr(0, J,         6'd0,      1'b1, 0);
    random_instrs(0, 40);

    do_release(1);
    run_instr(1, SW, 6'd0, 1'b0, 0);
    run_instr(1, LW, 6'd0, 1'b0, 0);
    random_instrs(1, 30);

    do_release(2);
    run_instr(2, LW, 6'd0, 1'b0, 0);
    run_instr(2, SW, 6'd0, 1'b0, 8);
    #2 rst_v[2] = 1'b0;
    #1 check_quiet(2, "mid_memwr_reset");
    check("d2 mid_memwr_reset memwrite", {31'd0, obs_v[2][14]}, 32'd0);
    @(negedge clk);
    check_quiet(2, "held_reset");
    rst_v[2] = 1'b1;
    #1 check_quiet(2, "post_mid_release");
    run_instr(2, LW, 6'd0, 1'b0, 0);
    random_instrs(2, 30);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
